mmio_timer: RTL and testbench

Memory-mapped machine timer. It is the responder on the core's data-memory port (chip-select, read/write, address, width mask) and the source of the machine timer interrupt consumed by the CSR/ISR logic. It holds a 64-bit free-running mtime, a 64-bit mtimecmp, a prescaler, and a sticky pending flag. The external address decoder asserts cs when the access targets this block's window.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/mmio_timer_lane_align.sv | 56 +++++
 rtl/mmio_timer.sv | 137 +++++++++++++
 tb/tb_mmio_timer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer and the data-memory lane logic.
// Register offsets, funct3 width codes and CTRL bit positions.
// No state; nothing to stall.
package timer_pkg;

    localparam logic [2:0] REG_MTIME_LO = 3'd0;
    localparam logic [2:0] REG_MTIME_HI = 3'd1;
    localparam logic [2:0] REG_CMP_LO   = 3'd2;
    localparam logic [2:0] REG_CMP_HI   = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;

    typedef enum logic [2:0] {
        MASK_B  = 3'b000,
        MASK_H  = 3'b001,
        MASK_W  = 3'b010,
        MASK_BU = 3'b100,
        MASK_HU = 3'b101
    } mask_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/mmio_timer_lane_align.sv
// Byte-lane store merge and load extract/extend for 32-bit word registers.
// Purely combinational, zero latency.
// No handshake; misaligned or unknown widths give be_o = 0 and rdata_o = 0.
module lane_align
    import timer_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  mask_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  sh;
    logic [31:0] wal;
    logic [31:0] bm;
    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b0000;
        wal     = 32'b0;
        rdata_o = 32'b0;
        sh      = {off_i, 3'b000};
        shifted = rword_i >> sh;
        case (mask_e'(mask_i))
            MASK_B, MASK_BU: begin
                be_o    = 4'b0001 << off_i;
                wal     = {24'b0, wdata_i[7:0]} << sh;
                rdata_o = (mask_i == MASK_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'b0, shifted[7:0]};
            end
            MASK_H, MASK_HU: begin
                if (!off_i[0]) begin
                    be_o    = 4'b0011 << off_i;
                    wal     = {16'b0, wdata_i[15:0]} << sh;
                    rdata_o = (mask_i == MASK_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                                 : {16'b0, shifted[15:0]};
                end
            end
            MASK_W: begin
                if (off_i == 2'b00) begin
                    be_o    = 4'b1111;
                    wal     = wdata_i;
                    rdata_o = shifted;
                end
            end
            default: ;
        endcase
        bm       = {{8{be_o[3]}}, {8{be_o[2]}}, {8{be_o[1]}}, {8{be_o[0]}}};
        merged_o = (old_i & ~bm) | (wal & bm);
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaler, sticky pending, level irq.
// Loads answer combinationally; stores commit at the rising edge; irq lags pending by one cycle.
// Always ready: every access completes in the cycle it is presented.
module mmio_timer
    import timer_pkg::*;
#(
    parameter int          PRESCALE_W = 16,
    parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_i,
    input  logic        wr_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  mask_i,
    output logic [31:0] rdata_o,
    output logic        timer_irq_o
);

    logic [63:0]           mtime_q, mtime_d, cmp_q, cmp_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d, cnt_q, cnt_d;
    logic                  en_q, en_d, irq_en_q, irq_en_d;
    logic                  pend_q, pend_d, irq_q, irq_d;
    logic [31:0]           shadow_q, shadow_d;

    logic [2:0]  idx;
    logic        rd_en, wr_en, tick, clr;
    logic [31:0] live_word, rd_word, lane_rd, merged;
    logic [3:0]  be;

    assign idx   = addr_i[4:2];
    assign rd_en = cs_i & ~wr_i;
    assign wr_en = cs_i & wr_i;

    // Stores merge into the live register; MTIME_HI loads see the shadow instead.
    always_comb begin
        live_word = 32'b0;
        case (idx)
            REG_MTIME_LO: live_word = mtime_q[31:0];
            REG_MTIME_HI: live_word = mtime_q[63:32];
            REG_CMP_LO:   live_word = cmp_q[31:0];
            REG_CMP_HI:   live_word = cmp_q[63:32];
            REG_CTRL:     live_word = {30'b0, irq_en_q, en_q};
            REG_STATUS:   live_word = {31'b0, pend_q};
            REG_PRESCALE: live_word = 32'(psc_q);
            default:      live_word = 32'b0;
        endcase
        rd_word = (idx == REG_MTIME_HI) ? shadow_q : live_word;
    end

    lane_align u_lane_align (
        .off_i    (addr_i[1:0]),
        .mask_i   (mask_i),
        .wdata_i  (wdata_i),
        .old_i    (live_word),
        .rword_i  (rd_word),
        .be_o     (be),
        .merged_o (merged),
        .rdata_o  (lane_rd)
    );

    assign rdata_o     = rd_en ? lane_rd : 32'b0;
    assign timer_irq_o = irq_q;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (en_q) begin
            if (cnt_q == psc_q) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        mtime_d  = mtime_q + {63'b0, tick};
        cmp_d    = cmp_q;
        psc_d    = psc_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        clr      = 1'b0;
        shadow_d = (rd_en && idx == REG_MTIME_LO) ? mtime_q[63:32] : shadow_q;

        if (wr_en && be != 4'b0000) begin
            case (idx)
                REG_MTIME_LO: mtime_d = {mtime_q[63:32], merged};
                REG_MTIME_HI: mtime_d = {merged, mtime_q[31:0]};
                REG_CMP_LO:   cmp_d[31:0]  = merged;
                REG_CMP_HI:   cmp_d[63:32] = merged;
                REG_CTRL: begin
                    en_d     = merged[CTRL_EN];
                    irq_en_d = merged[CTRL_IRQ_EN];
                end
                REG_STATUS:   clr = be[0] & merged[0];
                REG_PRESCALE: begin
                    psc_d = merged[PRESCALE_W-1:0];
                    cnt_d = '0;
                end
                default: ;
            endcase
        end

        // A set condition in the same cycle as a clear keeps the flag set.
        pend_d = pend_q & ~clr;
        if (en_q && (mtime_q >= cmp_q)) begin
            pend_d = 1'b1;
        end
        irq_d = pend_q & irq_en_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q  <= 64'b0;
            cmp_q    <= CMP_RESET;
            psc_q    <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
            shadow_q <= 32'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            psc_q    <= psc_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: one task per scenario, inline checks against hand-computed values.
module tb_mmio_timer;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_i;
    logic        wr_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  mask_i;
    logic [31:0] rdata_o;
    logic        timer_irq_o;

    int checks = 0;
    int errors = 0;

    mmio_timer dut (
        .clk         (clk),
        .reset       (reset),
        .cs_i        (cs_i),
        .wr_i        (wr_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mask_i      (mask_i),
        .rdata_o     (rdata_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk = ~clk;

    // Every bus task starts just after a falling edge and returns at the next one.
    task automatic bus_wr(input logic [4:0] a, input logic [2:0] m, input logic [31:0] d);
        cs_i = 1'b1; wr_i = 1'b1; addr_i = a; mask_i = m; wdata_i = d;
        @(negedge clk);
        cs_i = 1'b0; wr_i = 1'b0; wdata_i = 32'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, input logic [2:0] m, output logic [31:0] d);
        cs_i = 1'b1; wr_i = 1'b0; addr_i = a; mask_i = m;
        #1 d = rdata_o;
        @(negedge clk);
        cs_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        cs_i = 1'b0; wr_i = 1'b0; addr_i = 5'h0; wdata_i = 32'h0; mask_i = MASK_W;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", rdata_o, 32'h0); end
        checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", timer_irq_o); end
        reset = 1'b0;
        bus_rd(5'h08, MASK_W, d);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_cmp_lo got %h exp ffffffff", d); end
        bus_rd(5'h0C, MASK_W, d);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_cmp_hi got %h exp ffffffff", d); end
        bus_rd(5'h00, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mtime got %h exp 0", d); end
        bus_rd(5'h10, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        do_reset();
        bus_wr(5'h08, MASK_W, 32'd5);
        bus_wr(5'h0C, MASK_W, 32'd0);
        bus_wr(5'h10, MASK_W, 32'h3);
        bus_rd(5'h14, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_status_early got %h exp 0", d); end
        repeat (3) @(negedge clk);
        bus_rd(5'h00, MASK_W, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL irq_mtime4 got %h exp 4", d); end
        bus_rd(5'h14, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_status_at5 got %h exp 0", d); end
        checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL irq_lag got %b exp 0", timer_irq_o); end
        bus_rd(5'h14, MASK_W, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL irq_pending_set got %h exp 1", d); end
        checks++; if (timer_irq_o !== 1'b1) begin errors++; $display("FAIL irq_asserted got %b exp 1", timer_irq_o); end
        bus_wr(5'h14, MASK_W, 32'h1);
        bus_rd(5'h14, MASK_W, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL irq_w1c_set_wins got %h exp 1", d); end
        bus_wr(5'h08, MASK_W, 32'd100);
        bus_wr(5'h14, MASK_W, 32'h1);
        bus_rd(5'h14, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_cleared got %h exp 0", d); end
        checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL irq_dropped got %b exp 0", timer_irq_o); end
        repeat (10) @(negedge clk);
        checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL irq_stays_low got %b exp 0", timer_irq_o); end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        do_reset();
        bus_wr(5'h18, MASK_W, 32'd3);
        bus_wr(5'h10, MASK_W, 32'h1);
        repeat (4) @(negedge clk);
        bus_rd(5'h00, MASK_W, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL psc_first_tick got %h exp 1", d); end
        repeat (35) @(negedge clk);
        bus_rd(5'h00, MASK_W, d);
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL psc_40_cycles got %h exp a", d); end
    endtask

    task automatic test_shadow();
        logic [31:0] d;
        do_reset();
        bus_wr(5'h00, MASK_W, 32'hFFFFFFFF);
        bus_wr(5'h04, MASK_W, 32'h0);
        bus_wr(5'h10, MASK_W, 32'h1);
        @(negedge clk);
        bus_rd(5'h00, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL shadow_lo_carry got %h exp 0", d); end
        bus_wr(5'h04, MASK_W, 32'h5);
        bus_rd(5'h04, MASK_W, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL shadow_hi got %h exp 1", d); end
        bus_rd(5'h00, MASK_W, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL shadow_lo_after_hi_store got %h exp 2", d); end
        bus_rd(5'h04, MASK_W, d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL shadow_hi_relatch got %h exp 5", d); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        do_reset();
        bus_wr(5'h19, MASK_B, 32'h123456A5);
        bus_rd(5'h18, MASK_W, d);
        checks++; if (d !== 32'h0000A500) begin errors++; $display("FAIL lane_sb_merge got %h exp 0000a500", d); end
        bus_rd(5'h19, MASK_B, d);
        checks++; if (d !== 32'hFFFFFFA5) begin errors++; $display("FAIL lane_lb got %h exp ffffffa5", d); end
        bus_rd(5'h19, MASK_BU, d);
        checks++; if (d !== 32'h000000A5) begin errors++; $display("FAIL lane_lbu got %h exp 000000a5", d); end
        bus_rd(5'h18, MASK_H, d);
        checks++; if (d !== 32'hFFFFA500) begin errors++; $display("FAIL lane_lh got %h exp ffffa500", d); end
        bus_rd(5'h18, MASK_HU, d);
        checks++; if (d !== 32'h0000A500) begin errors++; $display("FAIL lane_lhu got %h exp 0000a500", d); end
        bus_wr(5'h1A, MASK_W, 32'hFFFFFFFF);
        bus_rd(5'h18, MASK_W, d);
        checks++; if (d !== 32'h0000A500) begin errors++; $display("FAIL lane_sw_misaligned got %h exp 0000a500", d); end
        bus_rd(5'h1A, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL lane_lw_misaligned got %h exp 0", d); end
    endtask

    task automatic test_same_cycle_and_reset();
        logic [31:0] d;
        do_reset();
        bus_wr(5'h0C, MASK_W, 32'h0);
        bus_wr(5'h08, MASK_W, 32'h10);
        bus_wr(5'h10, MASK_W, 32'h3);
        bus_wr(5'h00, MASK_W, 32'h10);
        bus_rd(5'h00, MASK_W, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL tick_store_wins got %h exp 10", d); end
        @(negedge clk);
        checks++; if (timer_irq_o !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b exp 1", timer_irq_o); end
        cs_i = 1'b1; wr_i = 1'b1; addr_i = 5'h08; mask_i = MASK_W; wdata_i = 32'h0;
        reset = 1'b1;
        #1;
        checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL async_reset_irq got %b exp 0", timer_irq_o); end
        @(negedge clk);
        reset = 1'b0; cs_i = 1'b0; wr_i = 1'b0;
        #1;
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL post_reset_rdata got %h exp 0", rdata_o); end
        @(negedge clk);
        bus_rd(5'h08, MASK_W, d);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL post_reset_cmp_lo got %h exp ffffffff", d); end
        bus_rd(5'h0C, MASK_W, d);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL post_reset_cmp_hi got %h exp ffffffff", d); end
        bus_rd(5'h00, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_mtime got %h exp 0", d); end
        bus_rd(5'h14, MASK_W, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_status got %h exp 0", d); end
        checks++; if (timer_irq_o !== 1'b0) begin errors++; $display("FAIL post_reset_irq got %b exp 0", timer_irq_o); end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_prescale();
        test_shadow();
        test_byte_lanes();
        test_same_cycle_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
